cordic_seq_ctrl: RTL and testbench

Second-generation sequencer for the CORDIC engine. It adds an input/output ready/valid handshake, a rotation/vectoring mode select, an optional normalisation step, a clamped run-time iteration count, abort, and explicit datapath enables.
- Sits between the operand source and the CORDIC datapath (x/y/z registers, barrel shifters, atan ROM).
- Owns only control; never touches data values.

---
 rtl/cordic_seq_ctrl_pkg.sv | 20 ++
 rtl/cordic_seq_ctrl_if.sv | 36 +++
 rtl/cordic_iter_counter.sv | 33 +++
 rtl/cordic_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared definitions for the CORDIC sequencer: FSM state encoding, mode
// constants and default sizing.
package cordic_seq_ctrl_pkg;

    localparam int ITER_WIDTH_DEFAULT = 4;
    localparam int MAX_ITER_DEFAULT   = 15;

    localparam logic MODE_VECT = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_NORMALIZE = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_FINALIZE  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Control bundle between operand source / result sink / CORDIC datapath and
// the sequencer. The sequencer takes the slave view.
interface cordic_seq_ctrl_if #(
    parameter int ITERATION_WIDTH = 4
);
    logic                       start;
    logic                       in_ready;
    logic                       mode;
    logic [ITERATION_WIDTH-1:0] n;
    logic                       norm_req;
    logic                       sign_y;
    logic                       sign_z;
    logic                       abort;
    logic                       ld_en;
    logic                       norm_en;
    logic                       iter_en;
    logic [ITERATION_WIDTH-1:0] shift_amt;
    logic                       dir;
    logic                       fin_en;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;
    logic                       n_clamped;

    modport master (
        output start, mode, n, norm_req, sign_y, sign_z, abort, out_ready,
        input  in_ready, ld_en, norm_en, iter_en, shift_amt, dir, fin_en,
               out_valid, busy, n_clamped
    );

    modport slave (
        input  start, mode, n, norm_req, sign_y, sign_z, abort, out_ready,
        output in_ready, ld_en, norm_en, iter_en, shift_amt, dir, fin_en,
               out_valid, busy, n_clamped
    );
endinterface

// File: rtl/cordic_iter_counter.sv
// Micro-rotation index counter with terminal detect against the effective
// iteration count.
module cordic_iter_counter
    import cordic_seq_ctrl_pkg::*;
#(
    parameter int ITERATION_WIDTH = ITER_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic [ITERATION_WIDTH-1:0] n_eff,
    output logic [ITERATION_WIDTH-1:0] idx,
    output logic                       last
);
    localparam logic [ITERATION_WIDTH-1:0] STEP = ITERATION_WIDTH'(1);
    localparam logic [ITERATION_WIDTH:0]   ONE  = (ITERATION_WIDTH + 1)'(1);

    logic [ITERATION_WIDTH-1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_reg <= '0;
        end else if (en) begin
            idx_reg <= idx_reg + STEP;
        end
    end

    // Compare idx+1 against n_eff one bit wider so n_eff=0 never aliases.
    assign last = (({1'b0, idx_reg} + ONE) == {1'b0, n_eff});
    assign idx  = idx_reg;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Control-only sequencer for the CORDIC datapath: operand handshake, optional
// normalisation, n_eff micro-rotations, finalise, and result handshake.
module cordic_seq_ctrl
    import cordic_seq_ctrl_pkg::*;
#(
    parameter int ITERATION_WIDTH = ITER_WIDTH_DEFAULT,
    parameter int MAX_ITER        = MAX_ITER_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    cordic_seq_ctrl_if.slave bus
);
    localparam logic [ITERATION_WIDTH-1:0] MAX_ITER_V = ITERATION_WIDTH'(MAX_ITER);

    state_t                     state_reg;
    state_t                     state_next;
    logic                       mode_reg;
    logic [ITERATION_WIDTH-1:0] n_eff_reg;
    logic                       n_clamped_reg;

    logic                       accept;
    logic                       cnt_clear;
    logic                       cnt_en;
    logic                       cnt_last;
    logic [ITERATION_WIDTH-1:0] idx;

    assign accept    = (state_reg == ST_IDLE) && bus.start && !bus.abort && !rst;
    assign cnt_clear = (state_reg == ST_LOAD);
    assign cnt_en    = (state_reg == ST_COMPUTE);

    cordic_iter_counter #(
        .ITERATION_WIDTH(ITERATION_WIDTH)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .n_eff (n_eff_reg),
        .idx   (idx),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_VECT;
            n_eff_reg     <= '0;
            n_clamped_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                mode_reg <= bus.mode;
                if (bus.n > MAX_ITER_V) begin
                    n_eff_reg     <= MAX_ITER_V;
                    n_clamped_reg <= 1'b1;
                end else begin
                    n_eff_reg     <= bus.n;
                    n_clamped_reg <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.abort)             state_next = ST_IDLE;
                else if (bus.norm_req)     state_next = ST_NORMALIZE;
                else if (n_eff_reg != '0)  state_next = ST_COMPUTE;
                else                       state_next = ST_FINALIZE;
            end
            ST_NORMALIZE: begin
                if (bus.abort)             state_next = ST_IDLE;
                else if (n_eff_reg != '0)  state_next = ST_COMPUTE;
                else                       state_next = ST_FINALIZE;
            end
            ST_COMPUTE: begin
                if (bus.abort)     state_next = ST_IDLE;
                else if (cnt_last) state_next = ST_FINALIZE;
            end
            ST_FINALIZE: begin
                state_next = bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // A simultaneous abort and out_ready still completes the transfer.
                if (bus.abort || bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.ld_en     = 1'b0;
        bus.norm_en   = 1'b0;
        bus.iter_en   = 1'b0;
        bus.shift_amt = '0;
        bus.dir       = 1'b0;
        bus.fin_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.n_clamped = 1'b0;
        if (!rst) begin
            bus.busy      = (state_reg != ST_IDLE);
            bus.n_clamped = n_clamped_reg;
            case (state_reg)
                ST_IDLE: begin
                    bus.in_ready = 1'b1;
                    bus.ld_en    = accept;
                end
                ST_NORMALIZE: bus.norm_en = 1'b1;
                ST_COMPUTE: begin
                    bus.iter_en   = 1'b1;
                    bus.shift_amt = idx;
                    bus.dir       = (mode_reg == MODE_ROT) ? ~bus.sign_z : ~bus.sign_y;
                end
                ST_FINALIZE: bus.fin_en    = 1'b1;
                ST_DONE:     bus.out_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: cycle-by-cycle output checks for the
// main paths, clamping, backpressure, abort and reset.
module tb_cordic_seq_ctrl;
    import cordic_seq_ctrl_pkg::*;

    localparam int W    = 4;
    localparam int MAXI = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_seq_ctrl_if #(.ITERATION_WIDTH(W)) bus();

    cordic_seq_ctrl #(
        .ITERATION_WIDTH(W),
        .MAX_ITER       (MAXI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic ir, input logic ld, input logic nm,
                        input logic it, input logic [W-1:0] sh, input logic fi,
                        input logic ov, input logic bz, input logic dr);
        chk({tag, ".in_ready"},  bus.in_ready,  ir);
        chk({tag, ".ld_en"},     bus.ld_en,     ld);
        chk({tag, ".norm_en"},   bus.norm_en,   nm);
        chk({tag, ".iter_en"},   bus.iter_en,   it);
        chk({tag, ".shift_amt"}, bus.shift_amt, sh);
        chk({tag, ".fin_en"},    bus.fin_en,    fi);
        chk({tag, ".out_valid"}, bus.out_valid, ov);
        chk({tag, ".busy"},      bus.busy,      bz);
        chk({tag, ".dir"},       bus.dir,       dr);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with cycle-exact expectations; out_ready granted on the
    // first DONE cycle. sign_y/sign_z are driven opposite so dir proves its source.
    task automatic run_op(input string tag, input logic m, input logic [W-1:0] nn,
                          input logic nr, input int exp_iters, input logic exp_clamp);
        logic exp_dir;
        cyc();
        bus.start = 1'b1; bus.mode = m; bus.n = nn; bus.norm_req = nr; bus.out_ready = 1'b0;
        #1;
        outs({tag, ".accept"}, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        bus.start = 1'b0;
        #1;
        outs({tag, ".load"}, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk({tag, ".n_clamped"}, bus.n_clamped, exp_clamp);
        cyc();
        bus.norm_req = 1'b0;
        if (nr) begin
            #1;
            outs({tag, ".norm"}, 0, 0, 1, 0, 0, 0, 0, 1, 0);
            cyc();
        end
        for (int i = 0; i < exp_iters; i++) begin
            bus.sign_y = i[0];
            bus.sign_z = ~i[0];
            exp_dir = m ? i[0] : ~i[0];
            #1;
            outs({tag, ".iter"}, 0, 0, 0, 1, i[W-1:0], 0, 0, 1, exp_dir);
            cyc();
        end
        #1;
        outs({tag, ".fin"}, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        cyc();
        bus.out_ready = 1'b1;
        #1;
        outs({tag, ".done"}, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc();
        bus.out_ready = 1'b0;
        #1;
        outs({tag, ".idle"}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn %s mode=%0d n=%0d norm=%0d iters=%0d", tag, m, nn, nr, exp_iters);
    endtask

    // Accept an operand and stop in the LOAD cycle.
    task automatic begin_op(input logic [W-1:0] nn);
        cyc();
        bus.start = 1'b1; bus.mode = MODE_VECT; bus.n = nn; bus.norm_req = 1'b0;
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.mode = 0; bus.n = '0; bus.norm_req = 0;
        bus.sign_y = 0; bus.sign_z = 0; bus.abort = 0; bus.out_ready = 0;

        // Reset: everything low while rst=1, idle afterwards.
        rst = 1'b1;
        cyc();
        bus.start = 1'b1;
        #1;
        outs("rst.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        outs("rst.idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.n_clamped", bus.n_clamped, 0);
        $display("txn reset");

        run_op("vect_n4",    MODE_VECT, 4'd4,  1'b0, 4,  1'b0);
        run_op("vect_norm2", MODE_VECT, 4'd2,  1'b1, 2,  1'b0);
        run_op("rot_norm2",  MODE_ROT,  4'd2,  1'b1, 2,  1'b0);
        run_op("clamp_n15",  MODE_VECT, 4'd15, 1'b0, 12, 1'b1);
        run_op("zero_n0",    MODE_ROT,  4'd0,  1'b0, 0,  1'b0);
        run_op("edge_n12",   MODE_VECT, 4'd12, 1'b0, 12, 1'b0);
        run_op("clamp_n13",  MODE_ROT,  4'd13, 1'b1, 12, 1'b1);
        run_op("norm_n0",    MODE_VECT, 4'd0,  1'b1, 0,  1'b0);

        // Backpressure: n=1 reaches DONE 4 cycles after accept, then stalls.
        begin_op(4'd1);
        cyc(); cyc(); cyc();
        #1;
        outs("bp.done", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            outs("bp.stall", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        end
        cyc();
        bus.out_ready = 1'b1;
        #1;
        outs("bp.xfer", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc();
        bus.out_ready = 1'b0;
        #1;
        outs("bp.after", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn backpressure");

        // Abort in COMPUTE at index 2 of n=8.
        begin_op(4'd8);
        cyc(); cyc(); cyc();
        bus.abort = 1'b1;
        bus.sign_y = 1'b0;
        #1;
        outs("abt.compute", 0, 0, 0, 1, 4'd2, 0, 0, 1, 1);
        cyc();
        bus.abort = 1'b0;
        #1;
        outs("abt.idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            #1;
            chk("abt.no_valid", bus.out_valid, 0);
        end
        $display("txn abort_compute");

        // Abort blocks accept in IDLE.
        cyc();
        bus.start = 1'b1; bus.abort = 1'b1; bus.n = 4'd3;
        #1;
        outs("abt.idle_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        bus.start = 1'b0; bus.abort = 1'b0;
        #1;
        chk("abt.not_accepted", bus.busy, 0);
        $display("txn abort_idle");

        // Abort in DONE without out_ready still returns to IDLE.
        begin_op(4'd0);
        cyc(); cyc();
        bus.abort = 1'b1;
        #1;
        outs("abt.done", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc();
        bus.abort = 1'b0;
        #1;
        outs("abt.done_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn abort_done");

        // Reset during COMPUTE discards the operation.
        begin_op(4'd4);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        outs("rstc.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        #1;
        outs("rstc.idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            chk("rstc.no_valid", bus.out_valid, 0);
        end
        $display("txn reset_compute");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
